// File: rtl/simd_reg_write_pacer_if.sv
// Result-stream and register-file write bundle for simd_reg_write_pacer.
// The slave side is the pacer; the master side feeds ALU results and observes writes.
interface simd_reg_write_pacer_if #(
  parameter int VSIZE    = 32,
  parameter int TDBW     = 16,
  parameter int ALU_BW   = 24,
  parameter int SRAM_ABW = 9
);
  logic                      i_valid;
  logic                      o_ready;
  logic [SRAM_ABW-1:0]       i_addr;
  logic [ALU_BW*VSIZE-1:0]   i_data;
  logic                      o_we;
  logic [SRAM_ABW-1:0]       o_waddr;
  logic [TDBW*VSIZE-1:0]     o_wdata;
  logic                      o_pending;
  logic [15:0]               o_npair;

  modport master (
    output i_valid, i_addr, i_data,
    input  o_ready, o_we, o_waddr, o_wdata, o_pending, o_npair
  );

  modport slave (
    input  i_valid, i_addr, i_data,
    output o_ready, o_we, o_waddr, o_wdata, o_pending, o_npair
  );
endinterface

// File: rtl/simd_reg_write_pacer.sv
// Narrows ALU result warps, buffers them and issues paced lo/hi register-file writes
// (never two strobes back to back). Define SIMD_WB_SAT_EN for signed lane saturation.
module simd_reg_write_pacer #(
  parameter int VSIZE      = 32,
  parameter int TDBW       = 16,
  parameter int ALU_BW     = 24,
  parameter int SRAM_ABW   = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  simd_reg_write_pacer_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = TDBW * VSIZE;
  localparam int ENT_W  = SRAM_ABW + DATA_W;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t              state_reg, state_next;
  logic [ENT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                in_hi_reg, out_hi_reg;
  logic [SRAM_ABW-1:0] lo_addr_reg;
  logic [SRAM_ABW-1:0] waddr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [15:0]         npair_reg;
  logic [DATA_W-1:0]   narrow_data;
  logic [SRAM_ABW-1:0] push_addr;
  logic                fifo_full, fifo_nonempty, push, pop;

  for (genvar gi = 0; gi < VSIZE; gi++) begin : g_lane
    logic [ALU_BW-1:0] lane;
    assign lane = bus.i_data[gi*ALU_BW +: ALU_BW];
`ifdef SIMD_WB_SAT_EN
    localparam logic [ALU_BW-1:0] LANE_MAX = {{(ALU_BW-TDBW+1){1'b0}}, {(TDBW-1){1'b1}}};
    localparam logic [ALU_BW-1:0] LANE_MIN = ~LANE_MAX;
    assign narrow_data[gi*TDBW +: TDBW] =
        ($signed(lane) > $signed(LANE_MAX)) ? LANE_MAX[TDBW-1:0] :
        ($signed(lane) < $signed(LANE_MIN)) ? LANE_MIN[TDBW-1:0] :
        lane[TDBW-1:0];
`else
    // Upper lane bits are deliberately dropped by truncation.
    logic lane_unused;
    assign lane_unused = ^lane;
    assign narrow_data[gi*TDBW +: TDBW] = lane[TDBW-1:0];
`endif
  end

  assign fifo_full     = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count_reg != '0);
  assign bus.o_ready   = !fifo_full && !i_rst;
  assign push          = bus.i_valid && bus.o_ready;
  // Hi beats reuse the row captured with their lo partner.
  assign push_addr     = in_hi_reg ? lo_addr_reg : bus.i_addr;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: state_next = GAP;
      GAP: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      in_hi_reg   <= 1'b0;
      out_hi_reg  <= 1'b0;
      lo_addr_reg <= '0;
      npair_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        in_hi_reg  <= !in_hi_reg;
        if (!in_hi_reg) begin
          lo_addr_reg <= bus.i_addr;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
      if (state_reg == WRITE) begin
        out_hi_reg <= !out_hi_reg;
        if (out_hi_reg) begin
          npair_reg <= npair_reg + 1'b1;
        end
      end
    end
  end

  // Buffer storage carries no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {push_addr, narrow_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else if (pop) begin
      {waddr_reg, wdata_reg} <= mem[rd_ptr_reg];
    end
  end

  assign bus.o_we      = (state_reg == WRITE);
  assign bus.o_waddr   = waddr_reg;
  assign bus.o_wdata   = wdata_reg;
  assign bus.o_npair   = npair_reg;
  assign bus.o_pending = fifo_nonempty || in_hi_reg || out_hi_reg;
endmodule
